// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple stage reused per nibble,
// LSB nibble first, with the carry registered between nibbles.
module four_bits_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_rip
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic             state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] nxt_res;
  logic [3:0]       s4;
  logic             co;

  four_bits_adder u_add (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (c_q),
    .sum  (s4),
    .cout (co)
  );

  // New nibble enters at the top; after NIB shifts it sits in place.
  if (NIB == 1) begin : g_one
    assign nxt_res = s4;
  end else begin : g_many
    assign nxt_res = {s4, res[WIDTH-1:4]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      cnt   <= '0;
      res   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            c_q   <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_q <= a_q >> 4;
          b_q <= b_q >> 4;
          c_q <= co;
          res <= nxt_res;
          if (cnt == LAST) begin
            sum   <= nxt_res;
            cout  <= co;
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: vector table plus
// hand-written multi-cycle sequences, WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

  localparam int NIB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done, cout;
  logic [15:0] sum;

  logic        start4;
  logic [3:0]  a4, b4;
  logic        cin4;
  logic        busy4, done4, cout4;
  logic [3:0]  sum4;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] prev_sum;
  logic        prev_cout;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] esum;
    logic        ecout;
  } vec_t;

  vec_t vt[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an add, optionally poke a stray start mid-run, check exact timing.
  task automatic run_op(input vec_t v, input bit poke);
    start = 1'b1; a = v.a; b = v.b; cin = v.cin;
    tick();
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk("sum_hold", 32'(sum), 32'(prev_sum));
      chk("cout_hold", 32'(cout), 32'(prev_cout));
      if (poke && i == 1) begin
        start = 1'b1; a = 16'hAAAA; b = 16'h5555;
      end else begin
        start = 1'b0; a = '0; b = '0;
      end
      tick();
    end
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("sum_res", 32'(sum), 32'(v.esum));
    chk("cout_res", 32'(cout), 32'(v.ecout));
    prev_sum = v.esum;
    prev_cout = v.ecout;
  endtask

  initial begin
    vec_t v;
    int ndone;

    vt.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
    vt.push_back('{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0});
    vt.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
    vt.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1});
    vt.push_back('{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0});
    vt.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
    vt.push_back('{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0});

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    prev_sum = '0; prev_cout = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    tick();

    foreach (vt[i]) begin
      run_op(vt[i], 1'b0);
      tick();
      chk("done_fall", 32'(done), 32'd0);
    end

    // Stray start during RUN must be ignored.
    v = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    run_op(v, 1'b1);
    ndone = 0;
    for (int i = 0; i < NIB + 3; i++) begin
      tick();
      if (done) ndone++;
      chk("ign_busy", 32'(busy), 32'd0);
    end
    chk("ign_ndone", 32'(ndone), 32'd0);
    chk("ign_sum", 32'(sum), 32'h5556);

    // Leave a nonzero result so the reset clear is visible.
    v = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    run_op(v, 1'b0);
    tick();
    start = 1'b1; a = 16'h8000; b = 16'h8000; cin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < NIB + 3; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("arst_quiet", 32'(ndone), 32'd0);
    prev_sum = '0; prev_cout = 1'b0;

    // Back-to-back: start accepted in the done cycle.
    v = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    run_op(v, 1'b0);
    start = 1'b1; a = 16'h7FFF; b = 16'h0001; cin = 1'b0;
    tick();
    start = 1'b0; a = '0; b = '0;
    chk("b2b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < NIB - 1; i++) begin
      tick();
      chk("b2b_run", 32'({busy, done}), 32'b10);
      chk("b2b_hold", 32'(sum), 32'h0100);
    end
    tick();
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_sum", 32'(sum), 32'h8000);
    chk("b2b_cout", 32'(cout), 32'd0);

    // WIDTH=4 instance: single nibble.
    tick();
    chk("w4_idle", 32'({busy4, done4}), 32'd0);
    start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    tick();
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    chk("w4_busy", 32'({busy4, done4}), 32'b10);
    chk("w4_hold", 32'(sum4), 32'h0);
    tick();
    chk("w4_done", 32'({busy4, done4}), 32'b01);
    chk("w4_sum", 32'(sum4), 32'hF);
    chk("w4_cout", 32'(cout4), 32'd1);
    tick();
    chk("w4_fall", 32'(done4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
